// File: rtl/sine_cos_arbiter.sv
// Round-robin sharing of one sine/cos generator between two burst requesters.
// Samples are captured into a single output register and streamed with valid/ready.
module sine_cos_arbiter #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   output logic [1:0]       ack,
   output logic             busy,
   output logic             gen_en,
   input  logic [WIDTH-1:0] gen_sine,
   input  logic [WIDTH-1:0] gen_cos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sine,
   output logic [WIDTH-1:0] out_cos,
   output logic             out_id,
   output logic             out_last
);

   typedef enum logic [1:0] {IDLE, GRANT, STREAM, DRAIN} state_t;

   state_t           state_reg, state_next;
   logic             ptr_reg;
   logic             gsel_reg, gsel_next;
   logic             owner_reg;
   logic [LEN_W-1:0] remaining_reg;
   logic [LEN_W-1:0] glen;
   logic             accept;

   assign glen   = gsel_reg ? len1 : len0;
   assign accept = out_valid & out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ack
         assign ack[gi] = (state_reg == GRANT) && (gsel_reg == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         gsel_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         gsel_reg  <= gsel_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      gsel_next  = gsel_reg;
      busy       = 1'b0;
      gen_en     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               // Contention goes to ptr; a lone requester wins outright.
               gsel_next  = (req == 2'b11) ? ptr_reg : req[1];
               state_next = GRANT;
            end
         end
         GRANT: begin
            busy       = 1'b1;
            state_next = (glen != '0) ? STREAM : IDLE;
         end
         STREAM: begin
            busy   = 1'b1;
            gen_en = (remaining_reg != '0) & (!out_valid | out_ready);
            if (remaining_reg == '0 || (gen_en && remaining_reg == LEN_W'(1)))
               state_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (accept)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_reg       <= 1'b0;
         owner_reg     <= 1'b0;
         remaining_reg <= '0;
         out_valid     <= 1'b0;
         out_sine      <= '0;
         out_cos       <= '0;
         out_id        <= 1'b0;
         out_last      <= 1'b0;
      end else begin
         if (state_reg == GRANT) begin
            remaining_reg <= glen;
            owner_reg     <= gsel_reg;
            ptr_reg       <= ~gsel_reg;
         end
         // A fresh capture overrides the clear when the slot turns over in one cycle.
         if (gen_en) begin
            out_sine      <= gen_sine;
            out_cos       <= gen_cos;
            out_id        <= owner_reg;
            out_last      <= (remaining_reg == LEN_W'(1));
            out_valid     <= 1'b1;
            remaining_reg <= remaining_reg - LEN_W'(1);
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sine_cos_arbiter.sv
// Randomized and directed bench for sine_cos_arbiter with a burst-level scoreboard.
module tb_sine_cos_arbiter;
   localparam int WIDTH = 8;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [1:0]       req = 2'b00;
   logic [LEN_W-1:0] len0 = '0;
   logic [LEN_W-1:0] len1 = '0;
   logic             out_ready = 1'b0;
   logic [1:0]       ack;
   logic             busy, gen_en, out_valid, out_id, out_last;
   logic [WIDTH-1:0] gen_sine, gen_cos, out_sine, out_cos;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic id;
      logic last;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_phase = 8'd0;
   logic       ptr_m = 1'b0;
   int         gen_cnt = 0;
   int         acc_cnt = 0;
   int         rdy_mode = 0;
   logic [7:0] last_sine = 8'd0;
   logic [7:0] last_cos = 8'd0;
   logic       last_id = 1'b0;
   logic [7:0] gen_phase = 8'd0;

   sine_cos_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
      .ack(ack), .busy(busy), .gen_en(gen_en),
      .gen_sine(gen_sine), .gen_cos(gen_cos),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sine(out_sine), .out_cos(out_cos),
      .out_id(out_id), .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sin_of(input logic [7:0] p);
      return 8'(p * 8'd7 + 8'd3);
   endfunction

   function automatic logic [7:0] cos_of(input logic [7:0] p);
      return 8'(p * 8'd13 + 8'd100);
   endfunction

   // Stand-in generator: phase advances on every enabled edge.
   always @(posedge clk) if (gen_en) gen_phase <= gen_phase + 8'd1;
   assign gen_sine = sin_of(gen_phase);
   assign gen_cos  = cos_of(gen_phase);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (k % 3 == 0); k++; end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Per-cycle scoreboard and protocol checks.
   initial begin
      logic       prev_hold;
      logic [7:0] hs, hc;
      logic       hi, hl;
      exp_t       e;
      prev_hold = 1'b0;
      hs = '0; hc = '0; hi = 1'b0; hl = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_hold = 1'b0;
            continue;
         end
         if (gen_en) gen_cnt++;
         if (!busy) chk("gen_en_when_idle", gen_en, 0);
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sine", out_sine, hs);
            chk("hold_cos", out_cos, hc);
            chk("hold_id", out_id, hi);
            chk("hold_last", out_last, hl);
         end
         if (out_valid && !out_ready) chk("bp_gen_en", gen_en, 0);
         if (out_valid && out_ready) begin
            chk("sample_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sample_sine", out_sine, sin_of(model_phase));
               chk("sample_cos", out_cos, cos_of(model_phase));
               chk("sample_id", out_id, e.id);
               chk("sample_last", out_last, e.last);
               model_phase = model_phase + 8'd1;
            end
            acc_cnt++;
            last_sine = out_sine;
            last_cos  = out_cos;
            last_id   = out_id;
         end
         prev_hold = out_valid && !out_ready;
         hs = out_sine; hc = out_cos; hi = out_id; hl = out_last;
      end
   end

   task automatic run_burst(input logic [1:0] r, input logic [7:0] l0, input logic [7:0] l1,
                            input int mode, output logic g_out);
      logic       g;
      logic [7:0] l;
      int         gc0, n;
      bit         got;
      exp_t       e;
      rdy_mode = mode;
      n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      chk("idle_before_req", busy, 0);
      @(posedge clk); #1;
      g = (r == 2'b11) ? ptr_m : r[1];
      l = g ? l1 : l0;
      ptr_m = ~g;
      for (int i = 0; i < int'(l); i++) begin
         e.id = g;
         e.last = (i == int'(l) - 1);
         exp_q.push_back(e);
      end
      gc0 = gen_cnt;
      req = r; len0 = l0; len1 = l1;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         if (ack != 2'b00) got = 1'b1;
      end
      chk("ack_seen", got, 1);
      chk("ack_onehot", ack, g ? 2'b10 : 2'b01);
      chk("busy_in_grant", busy, 1);
      chk("gen_en_in_grant", gen_en, 0);
      @(posedge clk); #1;
      req = 2'b00;
      len0 = 8'($urandom);
      len1 = 8'($urandom);
      @(negedge clk);
      chk("ack_one_cycle", ack, 0);
      chk("valid_first_stream", out_valid, 0);
      if (l == 0) chk("zero_len_back_idle", busy, 0);
      else chk("gen_en_first_stream", gen_en, 1);
      @(negedge clk);
      chk("valid_two_after_ack", out_valid, (l != 0));
      n = 0;
      while (busy && n < 64 * int'(l) + 50) begin @(negedge clk); n++; end
      chk("burst_done", busy, 0);
      chk("gen_en_pulses", gen_cnt - gc0, int'(l));
      chk("all_samples_delivered", exp_q.size(), 0);
      $display("burst req=%b granted=%0d len=%0d ready_mode=%0d", r, g, l, mode);
      g_out = g;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g;
      int   a0, n, gc0;

      // Reset values.
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gen_en", gen_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_sine", out_sine, 0);
      chk("rst_cos", out_cos, 0);
      chk("rst_id", out_id, 0);
      chk("rst_last", out_last, 0);
      @(posedge clk); #2; reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_gen_en", gen_en, 0);
         chk("idle_busy", busy, 0);
      end

      // Single burst, no backpressure; last sample is phase 3.
      run_burst(2'b01, 8'd4, 8'd0, 0, g);
      chk("t1_grant", g, 0);
      chk("t1_last_sine", last_sine, 8'd24);
      chk("t1_last_cos", last_cos, 8'd139);
      chk("t1_last_id", last_id, 0);

      // Reset pulse so arbitration pointer starts at 0.
      @(posedge clk); #2; reset = 1'b0;
      @(posedge clk); #2; reset = 1'b1;
      ptr_m = 1'b0;
      model_phase = gen_phase;

      run_burst(2'b11, 8'd2, 8'd3, 0, g);
      chk("sim_first_grant", g, 0);
      run_burst(2'b11, 8'd2, 8'd3, 0, g);
      chk("sim_second_grant", g, 1);
      run_burst(2'b11, 8'd2, 8'd3, 0, g);
      chk("sim_third_grant", g, 0);

      run_burst(2'b10, 8'd0, 8'd3, 1, g);
      chk("bp_grant", g, 1);

      run_burst(2'b10, 8'd0, 8'd0, 0, g);
      chk("zero_len_grant", g, 1);

      for (int t = 0; t < 25; t++) begin
         run_burst(2'($urandom_range(1, 3)), 8'($urandom_range(0, 12)),
                   8'($urandom_range(0, 12)), $urandom_range(0, 2), g);
      end

      // Reset in the middle of an 8-sample burst.
      rdy_mode = 0;
      n = 0;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      begin
         exp_t e;
         for (int i = 0; i < 8; i++) begin
            e.id = 1'b0;
            e.last = (i == 7);
            exp_q.push_back(e);
         end
      end
      req = 2'b01; len0 = 8'd8;
      n = 0;
      while (ack == 2'b00 && n < 5) begin @(negedge clk); n++; end
      chk("mid_ack", ack, 2'b01);
      @(posedge clk); #1; req = 2'b00;
      a0 = acc_cnt;
      n = 0;
      while (acc_cnt < a0 + 3 && n < 50) begin @(negedge clk); n++; end
      chk("mid_three_samples", acc_cnt - a0, 3);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_gen_en", gen_en, 0);
      chk("async_ack", ack, 0);
      chk("async_sine", out_sine, 0);
      chk("async_cos", out_cos, 0);
      chk("async_id", out_id, 0);
      chk("async_last", out_last, 0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      ptr_m = 1'b0;
      model_phase = gen_phase;
      gc0 = gen_cnt;
      repeat (10) begin
         @(negedge clk);
         chk("post_rst_valid", out_valid, 0);
         chk("post_rst_busy", busy, 0);
      end
      chk("post_rst_no_gen", gen_cnt - gc0, 0);
      $display("burst req=01 granted=0 len=8 abandoned by reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sine_cos_arbiter.md
Name: sine_cos_arbiter

Overview:
- Shares one sine_cos generator (WIDTH-bit sine/cos outputs, advances one step per clk while en=1) between two requesters, using round-robin arbitration.
- Each requester asks for a burst of LEN samples. The block drives the generator enable, captures each current sine/cos pair into an output register, and streams it to a single consumer with valid/ready backpressure.
- The generator only advances when a sample slot is free, so no samples are dropped or duplicated.

Parameters:
- WIDTH, 8, sample width of gen_sine/gen_cos and out_sine/out_cos.
- LEN_W, 8, width of the burst-length request fields.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  level request per requester; held until ack.
- len0  in  LEN_W  burst length for requester 0; sampled at grant.
- len1  in  LEN_W  burst length for requester 1; sampled at grant.
- ack  out  2  one-cycle pulse to the granted requester, in the GRANT cycle.
- busy  out  1  high in GRANT, STREAM and DRAIN.
- gen_en  out  1  enable to generator; generator advances at the clk edge where it is 1.
- gen_sine  in  WIDTH  current generator sine.
- gen_cos  in  WIDTH  current generator cos.
- out_valid  out  1  sample register holds data.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_sine  out  WIDTH  captured sine.
- out_cos  out  WIDTH  captured cos.
- out_id  out  1  requester that owns the sample.
- out_last  out  1  high on the final sample of a burst.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, ptr=0, remaining=0.
  - ack=0, busy=0, gen_en=0, out_valid=0.
  - out_sine=0, out_cos=0, out_id=0, out_last=0.
- Reset mid-burst: same values immediately; the burst is abandoned and not resumed.
- Arbitration, in IDLE with req!=0:
  - If only one bit is set, that requester is granted.
  - If both bits are set, ptr is granted.
  - Move to GRANT.
- GRANT (exactly 1 cycle):
  - ack[g]=1 and busy=1.
  - remaining <= len_g; owner <= g; ptr <= ~g.
  - Next state is STREAM if len_g!=0, otherwise IDLE (zero-length request: ack only, no samples).
- STREAM:
  - gen_en = (remaining!=0) & (!out_valid | out_ready). This is combinational from state and registers.
  - On a cycle with gen_en=1:
    - out_sine <= gen_sine; out_cos <= gen_cos.
    - out_id <= owner; out_valid <= 1.
    - out_last <= (remaining==1).
    - remaining <= remaining-1.
  - If out_valid & out_ready and gen_en=0, then out_valid <= 0.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: hold until the last sample is accepted (out_valid & out_ready), then out_valid <= 0 and go to IDLE.
- New grant timing: the next grant is evaluated in IDLE, so there is at least 1 idle cycle between bursts.
- Throughput: with out_ready held at 1, one sample per clk. First out_valid appears 2 cycles after ack (GRANT -> first STREAM edge).
- Backpressure: while out_valid=1 and out_ready=0:
  - gen_en=0.
  - out_* stable.
  - The generator phase is frozen.
- Requests during busy: ignored. req may drop only after ack; a req drop during a burst has no effect.
- ptr toggles only on grant. A lone requester may be granted back-to-back.
- Widths: remaining is LEN_W bits; maximum burst is 2^LEN_W-1 samples.

Test Plan:
- Reset value check: reset=0 -> all outputs 0. Release reset, req=0 -> stays IDLE, gen_en=0 indefinitely.
- Single burst, no backpressure: req=01, len0=4, out_ready=1.
  - ack=01 for 1 cycle.
  - gen_en high exactly 4 cycles.
  - 4 samples equal consecutive generator values, out_id=0, out_last on the 4th only.
  - busy falls after DRAIN.
- Simultaneous requests: req=11 after reset, len0=2, len1=3.
  - Requester 0 is granted first (ptr=0); 2 samples with id=0.
  - Then requester 1; 3 samples with id=1.
  - Re-assert both -> requester 0 granted again (ptr=0 after granting 1).
- Backpressure: len1=3, out_ready toggles 1,0,0,1,...
  - gen_en=0 and out_* held during each ready=0 cycle.
  - The 3 delivered samples equal 3 consecutive generator values (no skip or duplicate).
  - Total gen_en pulses=3.
- Zero-length request: req=10, len1=0 -> ack=10 pulse, gen_en never asserted, out_valid stays 0, back to IDLE next cycle.
- Reset mid-burst: len0=8, assert reset=0 after the 3rd sample.
  - Outputs clear asynchronously (before the next clk edge).
  - After release with req=00, no further samples are produced.
